// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the boot reset sequencer.
// Optional watchdog is enabled by defining RST_SEQ_WDOG_EN.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SOFT = 2'd1,
    CAUSE_WDOG = 2'd2
  } cause_e;

  // Register word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] OFF_BOOT_ADDR = 3'd0;
  localparam logic [2:0] OFF_CTRL      = 3'd1;
  localparam logic [2:0] OFF_HOLD_CYC  = 3'd2;
  localparam logic [2:0] OFF_STATUS    = 3'd3;
  localparam logic [2:0] OFF_WDOG_LOAD = 3'd4;
  localparam logic [2:0] OFF_WDOG_KICK = 3'd5;

  // CTRL bit positions
  localparam int CTRL_FETCH_EN = 0;
  localparam int CTRL_SOFT_RST = 1;

  // STATUS layout: [1:0] state, [5:4] last reset cause
  function automatic logic [31:0] status_word(input state_e s, input cause_e c);
    return {26'd0, c, 2'b00, s};
  endfunction

endpackage

// File: rtl/boot_rst_sequencer_if.sv
// APB slave bundle for the boot reset sequencer.
interface boot_rst_sequencer_if #(
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [PDATA_SIZE-1:0] PWDATA;
  logic [PDATA_SIZE-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/rst_seq_apb_regs.sv
// APB register file: decode, storage, SOFT_RST/KICK pulses and PSLVERR.
// Watchdog registers exist only when RST_SEQ_WDOG_EN is defined.
module rst_seq_apb_regs
  import rst_seq_pkg::*;
#(
  parameter int          PADDR_SIZE        = 32,
  parameter int          PDATA_SIZE        = 32,
  parameter logic [31:0] DEFAULT_BOOT_ADDR = 32'h1A00_0000,
  parameter logic [15:0] DEFAULT_HOLD_CYC  = 16'd16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  boot_rst_sequencer_if.slave        apb,
  input  state_e                     state_i,
  input  cause_e                     cause_i,
  output logic [31:0]                boot_addr_o,
  output logic                       fetch_en_o,
  output logic [15:0]                hold_cyc_o,
  output logic                       soft_rst_o
`ifdef RST_SEQ_WDOG_EN
  ,
  output logic [31:0]                wdog_load_o,
  output logic                       wdog_kick_o
`endif
);

  logic [2:0]  off;
  logic        wr;
  logic        writable;
  logic [31:0] rdata;
  logic [31:0] boot_addr_q;
  logic        fetch_en_q;
  logic [15:0] hold_cyc_q;
`ifdef RST_SEQ_WDOG_EN
  logic [31:0] wdog_load_q;
`endif

  // Address bits outside the word-offset field are intentionally ignored
  logic unused_paddr;
  assign unused_paddr = ^{apb.PADDR[PADDR_SIZE-1:5], apb.PADDR[1:0]};

  assign off = apb.PADDR[4:2];
  assign wr  = apb.PSEL & apb.PENABLE & apb.PWRITE;

  // Flag offsets that accept writes; STATUS and holes are rejected
  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    writable = 1'b0;
    case (off)
      OFF_BOOT_ADDR, OFF_CTRL, OFF_HOLD_CYC: writable = 1'b1;
`ifdef RST_SEQ_WDOG_EN
      OFF_WDOG_LOAD, OFF_WDOG_KICK:          writable = 1'b1;
`endif
      default:                               writable = 1'b0;
    endcase
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = wr & ~writable;

  // SOFT_RST and KICK are single-cycle strobes on the access phase, never stored
  assign soft_rst_o = wr && (off == OFF_CTRL) && apb.PWDATA[CTRL_SOFT_RST];
`ifdef RST_SEQ_WDOG_EN
  assign wdog_kick_o = wr && (off == OFF_WDOG_KICK);
  assign wdog_load_o = wdog_load_q;
`endif

  // Writable configuration registers
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_addr_q <= DEFAULT_BOOT_ADDR;
      fetch_en_q  <= 1'b0;
      hold_cyc_q  <= DEFAULT_HOLD_CYC;
`ifdef RST_SEQ_WDOG_EN
      wdog_load_q <= '0;
`endif
    end else if (wr) begin
      case (off)
        OFF_BOOT_ADDR: boot_addr_q <= apb.PWDATA[31:0];
        OFF_CTRL:      fetch_en_q  <= apb.PWDATA[CTRL_FETCH_EN];
        OFF_HOLD_CYC:  hold_cyc_q  <= apb.PWDATA[15:0];
`ifdef RST_SEQ_WDOG_EN
        OFF_WDOG_LOAD: wdog_load_q <= apb.PWDATA[31:0];
`endif
        default: ;
      endcase
    end
  end

  assign boot_addr_o = boot_addr_q;
  assign fetch_en_o  = fetch_en_q;
  assign hold_cyc_o  = hold_cyc_q;

  // Combinational read mux; returns zero when not selected
  always_comb begin
    rdata = '0;
    if (apb.PSEL) begin
      case (off)
        OFF_BOOT_ADDR: rdata = boot_addr_q;
        OFF_CTRL:      rdata = {31'd0, fetch_en_q};
        OFF_HOLD_CYC:  rdata = {16'd0, hold_cyc_q};
        OFF_STATUS:    rdata = status_word(state_i, cause_i);
`ifdef RST_SEQ_WDOG_EN
        OFF_WDOG_LOAD: rdata = wdog_load_q;
`endif
        default:       rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA = PDATA_SIZE'(rdata);

endmodule

// File: rtl/boot_rst_sequencer.sv
// Core-complex reset sequencer: hold, settle, run, with software and
// optional watchdog restart. Define RST_SEQ_WDOG_EN to add the watchdog.
module boot_rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int          PADDR_SIZE        = 32,
  parameter int          PDATA_SIZE        = 32,
  parameter logic [31:0] DEFAULT_BOOT_ADDR = 32'h1A00_0000,
  parameter logic [15:0] DEFAULT_HOLD_CYC  = 16'd16,
  parameter int          SETTLE_CYC        = 4
) (
  input  logic                PCLK,
  input  logic                RESETn,
  boot_rst_sequencer_if.slave apb,
  output logic                core_rst_no,
  output logic                fetch_en_o,
  output logic [31:0]         boot_addr_o
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

  state_e      state_q;
  cause_e      cause_q;
  logic [15:0] cnt_q;
  logic        core_rst_n_q;
  logic        fetch_en_q;
  logic [31:0] boot_addr_q;

  logic [31:0] boot_addr_reg;
  logic        ctrl_fetch_en;
  logic [15:0] hold_cyc;
  logic        soft_rst;
  logic        wdog_expire;
  logic        restart;

`ifdef RST_SEQ_WDOG_EN
  logic [31:0] wdog_load;
  logic        wdog_kick;
  logic [31:0] wdog_cnt_q;
`endif

  rst_seq_apb_regs #(
    .PADDR_SIZE        (PADDR_SIZE),
    .PDATA_SIZE        (PDATA_SIZE),
    .DEFAULT_BOOT_ADDR (DEFAULT_BOOT_ADDR),
    .DEFAULT_HOLD_CYC  (DEFAULT_HOLD_CYC)
  ) u_regs (
    .clk         (PCLK),
    .rst_n       (RESETn),
    .apb         (apb),
    .state_i     (state_q),
    .cause_i     (cause_q),
    .boot_addr_o (boot_addr_reg),
    .fetch_en_o  (ctrl_fetch_en),
    .hold_cyc_o  (hold_cyc),
    .soft_rst_o  (soft_rst)
`ifdef RST_SEQ_WDOG_EN
    ,
    .wdog_load_o (wdog_load),
    .wdog_kick_o (wdog_kick)
`endif
  );

`ifdef RST_SEQ_WDOG_EN
  // Expiry fires on the last RUN cycle; a kick in the same cycle overrides it
  assign wdog_expire = (state_q == S_RUN) && (wdog_load != '0) &&
                       (wdog_cnt_q == 32'd1) && !wdog_kick;
`else
  assign wdog_expire = 1'b0;
`endif

  // Soft reset takes priority over watchdog and over any counter terminal
  assign restart = soft_rst | wdog_expire;

  // Sequencer FSM with its counters and registered core-facing outputs
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_HOLD;
      cause_q      <= CAUSE_POR;
      cnt_q        <= DEFAULT_HOLD_CYC;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      boot_addr_q  <= DEFAULT_BOOT_ADDR;
`ifdef RST_SEQ_WDOG_EN
      wdog_cnt_q   <= '0;
`endif
    end else if (restart) begin
      state_q      <= S_HOLD;
      cause_q      <= soft_rst ? CAUSE_SOFT : CAUSE_WDOG;
      cnt_q        <= hold_cyc;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          fetch_en_q <= 1'b0;
          if (cnt_q == '0) begin
            // Boot address is only sampled as the core leaves reset
            boot_addr_q  <= boot_addr_reg;
            cnt_q        <= SETTLE_LOAD;
            state_q      <= S_SETTLE;
            core_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_SETTLE: begin
          fetch_en_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= S_RUN;
`ifdef RST_SEQ_WDOG_EN
            wdog_cnt_q <= wdog_load;
`endif
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_RUN: begin
          fetch_en_q <= ctrl_fetch_en;
`ifdef RST_SEQ_WDOG_EN
          if (wdog_kick) begin
            wdog_cnt_q <= wdog_load;
          end else if ((wdog_load != '0) && (wdog_cnt_q != '0)) begin
            wdog_cnt_q <= wdog_cnt_q - 32'd1;
          end
`endif
        end
        default: begin
          state_q      <= S_HOLD;
          cnt_q        <= hold_cyc;
          core_rst_n_q <= 1'b0;
          fetch_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst_no = core_rst_n_q;
  assign fetch_en_o  = fetch_en_q;
  assign boot_addr_o = boot_addr_q;

endmodule

// File: tb/tb_boot_rst_sequencer.sv
// Self-checking bench for boot_rst_sequencer: register table plus
// hand-written reset-sequence scenarios; watchdog cases under RST_SEQ_WDOG_EN.
module tb_boot_rst_sequencer;
  import rst_seq_pkg::*;

  logic        PCLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        core_rst_no;
  logic        fetch_en_o;
  logic [31:0] boot_addr_o;

  boot_rst_sequencer_if #(.PADDR_SIZE(32), .PDATA_SIZE(32)) apb ();

  boot_rst_sequencer #(
    .PADDR_SIZE        (32),
    .PDATA_SIZE        (32),
    .DEFAULT_BOOT_ADDR (32'h1A00_0000),
    .DEFAULT_HOLD_CYC  (16'd16),
    .SETTLE_CYC        (4)
  ) dut (
    .PCLK        (PCLK),
    .RESETn      (RESETn),
    .apb         (apb),
    .core_rst_no (core_rst_no),
    .fetch_en_o  (fetch_en_o),
    .boot_addr_o (boot_addr_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Background tallies so scenarios can test "never happened" by deltas
  int fetch_hi_cnt = 0;
  int rst_lo_cnt = 0;
  always @(negedge PCLK) begin
    if (fetch_en_o)   fetch_hi_cnt <= fetch_hi_cnt + 1;
    if (!core_rst_no) rst_lo_cnt   <= rst_lo_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer, entered and left on a falling edge; the access
  // completes on the rising edge just before the task returns.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    exp_t e;
    sb.push_back('{wr, exp_rdata, exp_err, name});
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = wdata;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    #1;
    e = sb.pop_front();
    check({e.name, " pslverr"}, {31'd0, apb.PSLVERR}, {31'd0, e.err});
    if (!e.wr) check({e.name, " prdata"}, apb.PRDATA, e.rdata);
    @(negedge PCLK);
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
  endtask

  // Called on a falling edge; counts consecutive sampled cycles with core in reset
  task automatic count_low(output int n);
    n = 0;
    while (!core_rst_no && n < 200) begin
      n++;
      @(negedge PCLK);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (core_rst_no && n < 200) begin
      n++;
      @(negedge PCLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int f0;
    int r0;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0;  apb.PWDATA = '0;

    // Register-map vectors, applied once the sequencer reaches S_RUN after POR
    vecs.push_back('{1'b0, 32'h00, 32'h0,         32'h1A00_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         32'h10,        1'b0});
    vecs.push_back('{1'b0, 32'h0C, 32'h0,         32'h2,         1'b0});
    vecs.push_back('{1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0C, 32'h0,         32'h2,         1'b0});
    vecs.push_back('{1'b1, 32'h08, 32'hFFFF_0005, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         32'h5,         1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h8000_0000, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,         32'h8000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h20, 32'h0,         32'h8000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h18, 32'h1234,      32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h1C, 32'h0,         32'h0,         1'b0});
`ifdef RST_SEQ_WDOG_EN
    vecs.push_back('{1'b1, 32'h10, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0,         32'h0,         1'b0});
`else
    vecs.push_back('{1'b1, 32'h10, 32'h5,         32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h10, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h14, 32'h1,         32'h0,         1'b1});
`endif

    // Power-on reset state
    repeat (3) @(negedge PCLK);
    check("por_core_rst", {31'd0, core_rst_no}, 32'd0);
    check("por_fetch", {31'd0, fetch_en_o}, 32'd0);
    check("por_boot_addr", boot_addr_o, 32'h1A00_0000);
    check("pready", {31'd0, apb.PREADY}, 32'd1);

    // POR hold is DEFAULT_HOLD_CYC+1 = 17 cycles, then settle, then run
    RESETn = 1'b1;
    f0 = fetch_hi_cnt;
    count_low(n);
    check("por_hold_len", n, 32'd17);
    check("por_boot_addr_after", boot_addr_o, 32'h1A00_0000);
    xfer(1'b0, 32'h0C, 32'h0, 32'h1, 1'b0, "status_settle");
    repeat (3) @(negedge PCLK);
    xfer(1'b0, 32'h0C, 32'h0, 32'h2, 1'b0, "status_run");
    check("por_no_fetch", fetch_hi_cnt - f0, 32'd0);

    foreach (vecs[i])
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
           $sformatf("vec%0d", i));
    check("boot_addr_not_direct", boot_addr_o, 32'h1A00_0000);

    // Soft reset: new BOOT_ADDR appears only on hold exit; HOLD_CYC=5 -> 6 cycles
    xfer(1'b1, 32'h04, 32'h2, 32'h0, 1'b0, "soft_rst_wr");
    check("soft_rst_asserts", {31'd0, core_rst_no}, 32'd0);
    check("boot_addr_held", boot_addr_o, 32'h1A00_0000);
    count_low(n);
    check("soft_hold_len", n, 32'd6);
    check("boot_addr_new", boot_addr_o, 32'h8000_0000);
    xfer(1'b0, 32'h0C, 32'h0, 32'h11, 1'b0, "status_soft_cause");
    check("ctrl_soft_reads0", 32'd0, 32'd0 | {31'd0, fetch_en_o});

    // HOLD_CYC=0 gives a single-cycle hold
    repeat (6) @(negedge PCLK);
    xfer(1'b1, 32'h08, 32'h0, 32'h0, 1'b0, "hold0_wr");
    xfer(1'b1, 32'h04, 32'h2, 32'h0, 1'b0, "hold0_soft");
    count_low(n);
    check("hold_zero_len", n, 32'd1);

    // FETCH_EN in S_RUN reaches fetch_en_o one cycle after the access
    repeat (8) @(negedge PCLK);
    xfer(1'b1, 32'h04, 32'h1, 32'h0, 1'b0, "fetch_wr");
    check("fetch_lag0", {31'd0, fetch_en_o}, 32'd0);
    @(negedge PCLK);
    check("fetch_lag1", {31'd0, fetch_en_o}, 32'd1);
    xfer(1'b0, 32'h04, 32'h0, 32'h1, 1'b0, "ctrl_readback");

    // FETCH_EN+SOFT_RST together, then a second soft reset inside S_SETTLE
    xfer(1'b1, 32'h08, 32'h3, 32'h0, 1'b0, "hold3_wr");
    xfer(1'b1, 32'h04, 32'h3, 32'h0, 1'b0, "fetch_soft_wr");
    check("fetch_soft_rst", {31'd0, core_rst_no}, 32'd0);
    check("fetch_soft_fetch", {31'd0, fetch_en_o}, 32'd0);
    f0 = fetch_hi_cnt;
    count_low(n);
    check("hold3_len", n, 32'd4);
    xfer(1'b1, 32'h04, 32'h3, 32'h0, 1'b0, "settle_soft_wr");
    check("settle_soft_rst", {31'd0, core_rst_no}, 32'd0);
    count_low(n);
    check("settle_soft_hold_len", n, 32'd4);
    check("no_fetch_pulse", fetch_hi_cnt - f0, 32'd0);
    n = 0;
    while (!fetch_en_o && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("settle_to_fetch", n, 32'd5);

    // RESETn mid-run restores every reset value, FETCH_EN included
    @(negedge PCLK);
    RESETn = 1'b0;
    #1;
    check("mid_rst_core", {31'd0, core_rst_no}, 32'd0);
    check("mid_rst_fetch", {31'd0, fetch_en_o}, 32'd0);
    check("mid_rst_boot", boot_addr_o, 32'h1A00_0000);
    @(negedge PCLK);
    RESETn = 1'b1;
    xfer(1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "mid_rst_ctrl");
    xfer(1'b0, 32'h08, 32'h0, 32'h10, 1'b0, "mid_rst_hold");
    xfer(1'b0, 32'h00, 32'h0, 32'h1A00_0000, 1'b0, "mid_rst_bootreg");
    xfer(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, "mid_rst_status");

`ifdef RST_SEQ_WDOG_EN
    // Watchdog without kicks: 4 settle + 10 run cycles, then cause=2
    xfer(1'b1, 32'h10, 32'd10, 32'h0, 1'b0, "wdog_load_wr");
    count_low(n);
    count_high(n);
    check("wdog_run_len", n, 32'd14);
    xfer(1'b0, 32'h0C, 32'h0, 32'h20, 1'b0, "wdog_cause");

    // Kicks every 8 cycles keep the core out of reset
    count_low(n);
    repeat (2) @(negedge PCLK);
    r0 = rst_lo_cnt;
    for (int k = 0; k < 6; k++) begin
      xfer(1'b1, 32'h14, 32'h1, 32'h0, 1'b0, $sformatf("kick%0d", k));
      repeat (6) @(negedge PCLK);
    end
    check("wdog_kicked_no_rst", rst_lo_cnt - r0, 32'd0);
`else
    r0 = rst_lo_cnt;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
